lane_striper: RTL

- Parametrised successor to the fixed lane controller.
- Accepts a word stream (valid/ready/last) and stripes consecutive words round-robin across 1..LANES active physical lanes.
- Emits one stripe per handshake to the per-lane encoders; a stripe holds one word per active lane.
- Pads short end-of-frame stripes with IDLE control words, supports a rotated lane base, and inserts broadcast ordered sets at stripe boundaries.

---
 rtl/lane_striper.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lane_striper.sv
// rtl/lane_striper.sv - round-robin word-to-lane striper with IDLE padding and ordered-set insertion
//
// Purpose: collects consecutive input words into stripes of N active lanes and
// hands each stripe to the per-lane encoders in one handshake. Short final
// stripes are padded with IDLE_WORD (ctrl=1). Ordered sets are broadcast on all
// active lanes, only at stripe boundaries.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_lanes, cfg_first          active lane count and physical lane of slot 0
//   in_valid/in_ready/in_last/in_data   input word stream
//   os_valid/os_ready/os_word     ordered-set insertion request
//   out_valid/out_ready/out_last  stripe handshake and end-of-frame marker
//   out_lane_en, out_ctrl         active-lane mask and per-lane control flags
//   out_data                      per-lane words, lane p at [p*DATA_W +: DATA_W]
module lane_striper #(
  parameter int LANES = 4,
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] IDLE_WORD = 64'h0707070707070707,
  localparam int CW = $clog2(LANES) + 1,
  localparam int FW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CW-1:0]           cfg_lanes,
  input  logic [FW-1:0]           cfg_first,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    os_valid,
  output logic                    os_ready,
  input  logic [DATA_W-1:0]       os_word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [LANES-1:0]        out_lane_en,
  output logic [LANES-1:0]        out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data
);

  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [FW:0]   LANES_F = (FW+1)'(LANES);

  // Collect buffer and the descriptor of the stripe it holds
  logic [DATA_W-1:0] slots [LANES];
  logic [CW-1:0]     cnt_q;
  logic              pending_q;
  logic [CW-1:0]     n_q;
  logic [FW-1:0]     base_q;
  logic [CW-1:0]     fill_q;
  logic              os_q;
  logic              last_q;

  // Sanitised configuration
  logic [CW-1:0] n_cfg;
  logic [FW:0]   first_ext;
  logic [FW:0]   base_cfg_w;
  logic [FW-1:0] base_cfg;
  logic [CW-1:0] n_eff;
  logic [CW-1:0] cnt_inc;

  assign n_cfg = (cfg_lanes == '0)     ? CW'(1)  :
                 (cfg_lanes > LANES_C) ? LANES_C : cfg_lanes;

  // cfg_first can only exceed LANES-1 by less than LANES, so one subtraction wraps it
  assign first_ext  = {1'b0, cfg_first};
  assign base_cfg_w = (first_ext >= LANES_F) ? first_ext - LANES_F : first_ext;
  assign base_cfg   = base_cfg_w[FW-1:0];

  // The first word of a stripe must be judged against the config it latches
  assign n_eff   = (cnt_q == '0) ? n_cfg : n_q;
  assign cnt_inc = cnt_q + CW'(1);

  assign os_ready = !rst && os_valid && (cnt_q == '0) && !pending_q;
  assign in_ready = !rst && !pending_q && !(os_valid && (cnt_q == '0));

  // Map the pending stripe onto physical lanes
  logic [LANES-1:0]        lane_en_d;
  logic [LANES-1:0]        ctrl_d;
  logic [LANES*DATA_W-1:0] data_d;
  int                      phys;

  always_comb begin
    lane_en_d = '0;
    ctrl_d    = '0;
    data_d    = '0;
    phys      = 0;
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < n_q) begin
        phys = int'(base_q) + k;
        if (phys >= LANES) phys = phys - LANES;
        lane_en_d[phys] = 1'b1;
        if (CW'(k) < fill_q) begin
          data_d[phys*DATA_W +: DATA_W] = slots[k];
          ctrl_d[phys]                  = os_q;
        end else begin
          data_d[phys*DATA_W +: DATA_W] = IDLE_WORD;
          ctrl_d[phys]                  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      n_q         <= CW'(1);
      base_q      <= '0;
      fill_q      <= '0;
      os_q        <= 1'b0;
      last_q      <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_lane_en <= '0;
      out_ctrl    <= '0;
      out_data    <= '0;
    end else begin
      if (os_ready) begin
        n_q       <= n_cfg;
        base_q    <= base_cfg;
        for (int k = 0; k < LANES; k++) slots[k] <= os_word;
        fill_q    <= n_cfg;
        os_q      <= 1'b1;
        last_q    <= 1'b0;
        pending_q <= 1'b1;
      end else if (in_valid && in_ready) begin
        if (cnt_q == '0) begin
          n_q    <= n_cfg;
          base_q <= base_cfg;
        end
        for (int k = 0; k < LANES; k++) begin
          if (cnt_q == CW'(k)) slots[k] <= in_data;
        end
        if ((cnt_inc == n_eff) || in_last) begin
          pending_q <= 1'b1;
          fill_q    <= cnt_inc;
          last_q    <= in_last;
          os_q      <= 1'b0;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end

      // Accepts are blocked while pending, so this never races the sets above
      if (pending_q && (!out_valid || out_ready)) begin
        pending_q   <= 1'b0;
        out_valid   <= 1'b1;
        out_last    <= last_q;
        out_lane_en <= lane_en_d;
        out_ctrl    <= ctrl_d;
        out_data    <= data_d;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
